// File: rtl/button_pkg.sv
// Shared types and default timing constants for the pushbutton input blocks.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // 10 ms debounce and 1 s long press at a 100 MHz clock.
  localparam int unsigned DEBOUNCE_CYCLES_DEF   = 1_000_000;
  localparam int unsigned LONG_PRESS_CYCLES_DEF = 100_000_000;

endpackage

// File: rtl/button_debounce_if.sv
// Signal bundle between a raw pushbutton source and the debouncer.
interface button_debounce_if;
  import button_pkg::*;

  // btn_in carries no valid/ready: it is sampled every cycle. Every *_pulse
  // output is a single-cycle strobe with no backpressure; state is debug-only.
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press_pulse;
  logic [7:0] press_count;
  state_t     state;

  modport master (
    output btn_in,
    input  btn_level, press_pulse, release_pulse, long_press_pulse,
    input  press_count, state
  );

  modport slave (
    input  btn_in,
    output btn_level, press_pulse, release_pulse, long_press_pulse,
    output press_count, state
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer: press/release/long-press strobes and a press counter.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  button_debounce_if.slave   bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);

  // The sample that leaves IDLE/PRESSED already counts as the first stable one.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_PRESS_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_PRESS_CYCLES - 1);

  logic          btn_s;
  state_t        state;
  logic [DW-1:0] stab_cnt;
  logic [LW-1:0] long_cnt;
  logic          level_q;
  logic          press_q;
  logic          release_q;
  logic          long_q;
  logic [7:0]    count_q;
  logic          release_done;
  logic          long_run;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.btn_in),
    .q     (btn_s)
  );

  // The cycle that completes a release ends the press, so the long-press
  // timer stops there and cannot strobe alongside release_pulse.
  assign release_done = (state == RELEASE_WAIT) && !btn_s && (stab_cnt == DEB_LAST);
  assign long_run     = (state == PRESSED) || ((state == RELEASE_WAIT) && !release_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stab_cnt  <= '0;
      long_cnt  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;

      case (state)
        IDLE: begin
          if (btn_s) begin
            state    <= PRESS_WAIT;
            stab_cnt <= DW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state    <= IDLE;
            stab_cnt <= '0;
          end else if (stab_cnt == DEB_LAST) begin
            state    <= PRESSED;
            stab_cnt <= '0;
            level_q  <= 1'b1;
            press_q  <= 1'b1;
            count_q  <= count_q + 8'd1;
            long_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state    <= RELEASE_WAIT;
            stab_cnt <= DW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state    <= PRESSED;
            stab_cnt <= '0;
          end else if (release_done) begin
            state     <= IDLE;
            stab_cnt  <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          stab_cnt <= '0;
        end
      endcase

      // Saturating timer: one strobe per press, no wrap.
      if (long_run && (long_cnt != LONG_MAX)) begin
        long_cnt <= long_cnt + 1'b1;
        long_q   <= (long_cnt == LONG_LAST);
      end
    end
  end

  assign bus.btn_level        = level_q;
  assign bus.press_pulse      = press_q;
  assign bus.release_pulse    = release_q;
  assign bus.long_press_pulse = long_q;
  assign bus.press_count      = count_q;
  assign bus.state            = state;

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, SHALL be the consecutive stable synchronized samples required to accept a level change (10 ms @ 100 MHz).
REQ-002 Parameter LONG_PRESS_CYCLES, default 100_000_000, SHALL be the cycles a debounced press must persist to flag a long press (1 s @ 100 MHz).
REQ-003 Port clk, input, 1, SHALL be the single system clock, 100 MHz nominal.
REQ-004 Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 Port btn_in, input, 1, SHALL be the raw, asynchronous, bouncing pushbutton, active-high.
REQ-006 Port btn_level, output, 1, SHALL be the debounced button level.
REQ-007 Port press_pulse, output, 1, SHALL be a one-cycle strobe on each accepted press.
REQ-008 Port release_pulse, output, 1, SHALL be a one-cycle strobe on each accepted release.
REQ-009 Port long_press_pulse, output, 1, SHALL be a one-cycle strobe when a press reaches LONG_PRESS_CYCLES.
REQ-010 Port press_count, output, 8, SHALL be the number of accepted presses, modulo 256.

Function
REQ-011 btn_in SHALL pass through a two-flop synchronizer; only its output (btn_s) drives the rest of the logic.
REQ-012 The FSM SHALL have states IDLE (released, stable), PRESS_WAIT, PRESSED (pressed, stable), and RELEASE_WAIT.
REQ-013 Transitions from IDLE: btn_s=1 -> PRESS_WAIT with the stability counter loaded to 1.
REQ-014 Transitions from PRESS_WAIT:
- btn_s=0 (bounce) -> IDLE, counter cleared, no pulse.
- counter reaching DEBOUNCE_CYCLES -> PRESSED.
REQ-015 Transitions from PRESSED: btn_s=0 -> RELEASE_WAIT, symmetric to REQ-013.
REQ-016 Transitions from RELEASE_WAIT:
- btn_s=1 -> PRESSED with no pulse; the long-press timer is not reset.
- counter reaching DEBOUNCE_CYCLES -> IDLE.
REQ-017 press_pulse SHALL assert for exactly the first cycle in PRESSED entered from PRESS_WAIT.
- press_count increments in that same cycle.
- press_count wraps 255 -> 0 without saturating.
REQ-018 release_pulse SHALL assert for exactly the first cycle in IDLE entered from RELEASE_WAIT.
REQ-019 btn_level SHALL be registered: 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
REQ-020 The long-press timer SHALL behave as follows:
- clears on entry to PRESSED from PRESS_WAIT;
- counts every cycle in PRESSED or RELEASE_WAIT;
- at LONG_PRESS_CYCLES, asserts long_press_pulse for one cycle, at most once per press;
- saturates, so there is no wrap and no repeat pulse.
REQ-021 Counter widths SHALL be $clog2(parameter+1); no overflow is permitted at any parameter value >= 2.
REQ-022 At most one of press_pulse and release_pulse SHALL be high in any cycle; long_press_pulse may coincide with neither.
REQ-023 Accepted-press latency SHALL be 2 (synchronizer) + DEBOUNCE_CYCLES cycles from a clean btn_in rise to press_pulse.

Reset
REQ-024 Asserting rst_n=0 at any time, including mid-debounce or mid-long-press, SHALL immediately force the following:
- state IDLE;
- all counters 0;
- press_count 0;
- all pulses and btn_level 0;
- synchronizer flops 0.
REQ-025 After rst_n deasserts with btn_in held high, a press SHALL be accepted normally via PRESS_WAIT; it is not suppressed.

Structure
REQ-026 A shared package button_pkg SHALL hold the FSM state enum and the default DEBOUNCE_CYCLES and LONG_PRESS_CYCLES constants.
REQ-027 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, async active-low reset), reusable by other input blocks.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-028 Clean press: btn_in 0->1 held -> press_pulse high exactly at cycle 6 after the edge, btn_level=1, press_count=1.
REQ-029 Bounce: btn_in 1 for 3 cycles, 0 for 1, then 1 held -> exactly one press_pulse, no release_pulse, press_count=1.
REQ-030 Long press: hold 30 cycles after acceptance -> exactly one long_press_pulse, 20 cycles after press_pulse; release -> one release_pulse.
REQ-031 Release glitch: while PRESSED, btn_in 0 for 2 cycles then 1 -> no release_pulse, btn_level stays 1, long-press timing unchanged.
REQ-032 Wrap: 256 clean presses -> press_count returns to 0; 257th press -> 1.
REQ-033 Reset mid-operation: rst_n low during PRESS_WAIT and again during PRESSED -> all outputs 0 asynchronously; no pulse is emitted on the reset edge.
